pipe_barrel_shifter: RTL and testbench

PIPE_BARREL_SHIFTER -- requirements
Module: pipe_barrel_shifter

---
 rtl/pipe_barrel_shifter_if.sv | 29 ++
 rtl/pipe_barrel_shifter.sv | 127 ++++++++++++
 tb/tb_pipe_barrel_shifter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_barrel_shifter_if.sv
// Valid/ready handshake bundle for pipe_barrel_shifter: the operand side and the result side.
// The DUT uses the slave modport. A driving testbench or upstream block uses the master modport.
interface pipe_barrel_shifter_if #(
    parameter int unsigned DATA_SIZE = 8
);
    localparam int unsigned SEL_W = $clog2(DATA_SIZE);

    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_SIZE-1:0] data_in;
    logic [SEL_W-1:0]     select;
    logic [1:0]           mode;
    logic                 dir;

    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_SIZE-1:0] data_out;
    logic                 out_lost;

    modport master (
        output in_valid, data_in, select, mode, dir, out_ready,
        input  in_ready, out_valid, data_out, out_lost
    );

    modport slave (
        input  in_valid, data_in, select, mode, dir, out_ready,
        output in_ready, out_valid, data_out, out_lost
    );
endinterface

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter with log2(DATA_SIZE) stages. Stage k shifts by 2^k.
// The whole pipe freezes while the last stage holds a result that downstream is not taking.
module pipe_barrel_shifter #(
    parameter int unsigned DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_barrel_shifter_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(DATA_SIZE);
    localparam logic [1:0]  MODE_ARITH = 2'b01;
    localparam logic [1:0]  MODE_ROT   = 2'b10;
    localparam logic [DATA_SIZE-1:0] ONES = '1;

    logic [DATA_SIZE-1:0] st_data  [SEL_W];
    logic                 st_valid [SEL_W];
    logic [SEL_W-1:0]     st_sel   [SEL_W];
    logic [1:0]           st_mode  [SEL_W];
    logic                 st_dir   [SEL_W];
    logic                 st_lost  [SEL_W];

    logic [DATA_SIZE-1:0] nxt_data  [SEL_W];
    logic                 nxt_valid [SEL_W];
    logic [SEL_W-1:0]     nxt_sel   [SEL_W];
    logic [1:0]           nxt_mode  [SEL_W];
    logic                 nxt_dir   [SEL_W];
    logic                 nxt_lost  [SEL_W];

    logic stall;

    assign stall         = st_valid[SEL_W-1] & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = st_valid[SEL_W-1];
    assign bus.data_out  = st_data[SEL_W-1];
    assign bus.out_lost  = st_lost[SEL_W-1];

    // The select field is consumed LSB-first. Each stage passes on the bits that are still unused, shifted down.
    always_comb begin : stage_logic
        logic [DATA_SIZE-1:0] d;
        logic [DATA_SIZE-1:0] fill;
        logic                 v;
        logic [SEL_W-1:0]     s;
        logic [1:0]           m;
        logic                 dr;
        logic                 lost;
        int unsigned          amt;

        d    = '0;
        fill = '0;
        v    = 1'b0;
        s    = '0;
        m    = '0;
        dr   = 1'b0;
        lost = 1'b0;
        amt  = 0;
        for (int unsigned k = 0; k < SEL_W; k++) begin
            nxt_data[k]  = '0;
            nxt_valid[k] = 1'b0;
            nxt_sel[k]   = '0;
            nxt_mode[k]  = '0;
            nxt_dir[k]   = 1'b0;
            nxt_lost[k]  = 1'b0;
        end

        for (int unsigned k = 0; k < SEL_W; k++) begin
            if (k == 0) begin
                d    = bus.data_in;
                v    = bus.in_valid;
                s    = bus.select;
                m    = bus.mode;
                dr   = bus.dir;
                lost = 1'b0;
            end else begin
                d    = st_data[k-1];
                v    = st_valid[k-1];
                s    = st_sel[k-1];
                m    = st_mode[k-1];
                dr   = st_dir[k-1];
                lost = st_lost[k-1];
            end
            amt  = 1 << k;
            fill = {DATA_SIZE{d[DATA_SIZE-1]}};

            nxt_data[k]  = d;
            nxt_lost[k]  = lost;
            nxt_valid[k] = v;
            nxt_sel[k]   = s >> 1;
            nxt_mode[k]  = m;
            nxt_dir[k]   = dr;

            if (s[0]) begin
                if (m == MODE_ROT) begin
                    nxt_data[k] = dr ? ((d >> amt) | (d << (DATA_SIZE - amt)))
                                     : ((d << amt) | (d >> (DATA_SIZE - amt)));
                end else if (dr) begin
                    nxt_data[k] = (d >> amt) | ((m == MODE_ARITH) ? (~(ONES >> amt) & fill) : '0);
                    nxt_lost[k] = lost | (|(d << (DATA_SIZE - amt)));
                end else begin
                    nxt_data[k] = d << amt;
                    nxt_lost[k] = lost | (|(d >> (DATA_SIZE - amt)));
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < SEL_W; k++) begin
                st_data[k]  <= '0;
                st_valid[k] <= 1'b0;
                st_sel[k]   <= '0;
                st_mode[k]  <= '0;
                st_dir[k]   <= 1'b0;
                st_lost[k]  <= 1'b0;
            end
        end else if (!stall) begin
            for (int unsigned k = 0; k < SEL_W; k++) begin
                st_data[k]  <= nxt_data[k];
                st_valid[k] <= nxt_valid[k];
                st_sel[k]   <= nxt_sel[k];
                st_mode[k]  <= nxt_mode[k];
                st_dir[k]   <= nxt_dir[k];
                st_lost[k]  <= nxt_lost[k];
            end
        end
    end
endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Scoreboard bench for pipe_barrel_shifter with DATA_SIZE=8 (three stages, latency 3).
// Each scenario task drives operands, queues the expected result, and checks it when the result is transferred.
module tb_pipe_barrel_shifter;
    localparam int unsigned W = 8;

    typedef struct packed {
        logic [7:0]  data;
        logic        lost;
        logic [31:0] t;
    } exp_t;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] s;
        logic [1:0] m;
        logic       dr;
        logic [7:0] ed;
        logic       el;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        exp_q[$];

    pipe_barrel_shifter_if #(.DATA_SIZE(W)) bus ();

    pipe_barrel_shifter #(.DATA_SIZE(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model. Each output bit is computed from the source-bit index.
    function automatic logic [W:0] model(input logic [7:0] d, input int unsigned s,
                                         input logic [1:0] m, input logic dr);
        logic [7:0] r;
        logic       lost;
        r    = '0;
        lost = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (m == 2'b10)
                r[i] = dr ? d[(i + s) % W] : d[(i + W - s) % W];
            else if (!dr)
                r[i] = (i >= s) ? d[i - s] : 1'b0;
            else
                r[i] = (i + s < W) ? d[i + s] : ((m == 2'b01) ? d[W-1] : 1'b0);
        end
        if (m != 2'b10)
            for (int j = 0; j < s; j++) lost |= dr ? d[j] : d[W-1-j];
        return {lost, r};
    endfunction

    task automatic set_in(input logic v, input logic [7:0] d, input logic [2:0] s,
                          input logic [1:0] m, input logic dr);
        bus.in_valid = v;
        bus.data_in  = d;
        bus.select   = s;
        bus.mode     = m;
        bus.dir      = dr;
    endtask

    task automatic test_reset();
        logic        seen;
        int unsigned waited;
        @(negedge clk);
        set_in(1'b1, 8'hA5, 3'd1, 2'b00, 1'b0);
        bus.out_ready = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_no_capture got=%b exp=0", bus.out_valid); end
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_ghost_output got=%b exp=0", seen); end

        // Park a result in the stalled output stage, then reset in the middle of a cycle.
        @(negedge clk);
        set_in(1'b1, 8'h41, 3'd1, 2'b00, 1'b0);
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        waited = 0;
        while (!bus.out_valid && waited < 10) begin @(negedge clk); waited++; end
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.data_out !== 8'h82) begin
            n_bad++; $display("FAIL pre_reset_result got=%b/%h exp=1/82", bus.out_valid, bus.data_out);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL async_out_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.data_out !== 8'h00) begin n_bad++; $display("FAIL async_data_out got=%h exp=00", bus.data_out); end
        n_cmp++; if (bus.out_lost !== 1'b0) begin n_bad++; $display("FAIL async_out_lost got=%b exp=0", bus.out_lost); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL async_in_ready got=%b exp=1", bus.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_vectors();
        vec_t        vt[12];
        exp_t        e;
        int unsigned idx;
        int unsigned budget;
        vt[0]  = '{8'hB6, 3'd3, 2'b00, 1'b1, 8'h16, 1'b1};
        vt[1]  = '{8'hB6, 3'd2, 2'b01, 1'b1, 8'hED, 1'b1};
        vt[2]  = '{8'hB6, 3'd3, 2'b10, 1'b0, 8'hB5, 1'b0};
        vt[3]  = '{8'h0F, 3'd0, 2'b00, 1'b0, 8'h0F, 1'b0};
        vt[4]  = '{8'h01, 3'd7, 2'b00, 1'b0, 8'h80, 1'b0};
        vt[5]  = '{8'hB6, 3'd3, 2'b11, 1'b1, 8'h16, 1'b1};
        vt[6]  = '{8'hB6, 3'd1, 2'b01, 1'b0, 8'h6C, 1'b1};
        vt[7]  = '{8'hB6, 3'd3, 2'b10, 1'b1, 8'hD6, 1'b0};
        vt[8]  = '{8'h7F, 3'd4, 2'b01, 1'b1, 8'h07, 1'b1};
        vt[9]  = '{8'h80, 3'd7, 2'b01, 1'b1, 8'hFF, 1'b0};
        vt[10] = '{8'h80, 3'd1, 2'b00, 1'b0, 8'h00, 1'b1};
        vt[11] = '{8'h01, 3'd1, 2'b00, 1'b1, 8'h00, 1'b1};
        idx = 0;
        budget = 0;
        while ((idx < 12 || exp_q.size() != 0) && budget < 200) begin
            @(negedge clk);
            budget++;
            bus.out_ready = 1'b1;
            if (idx < 12) set_in(1'b1, vt[idx].d, vt[idx].s, vt[idx].m, vt[idx].dr);
            else bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL vec_unexpected got=%h exp=none", bus.data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.data_out !== e.data) begin n_bad++; $display("FAIL vec_data got=%h exp=%h", bus.data_out, e.data); end
                    n_cmp++; if (bus.out_lost !== e.lost) begin n_bad++; $display("FAIL vec_lost got=%b exp=%b", bus.out_lost, e.lost); end
                    n_cmp++; if (cyc - e.t !== 3) begin n_bad++; $display("FAIL vec_latency got=%0d exp=3", cyc - e.t); end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back('{vt[idx].ed, vt[idx].el, cyc});
                idx++;
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (idx != 12 || exp_q.size() != 0) begin n_bad++; $display("FAIL vec_timeout got=%0d/%0d exp=12/0", idx, exp_q.size()); end
    endtask

    task automatic test_stall();
        exp_t        e;
        logic        seen;
        int unsigned hold;
        int unsigned idx;
        int unsigned got;
        int unsigned budget;
        seen = 1'b0;
        hold = 0;
        idx = 0;
        got = 0;
        budget = 0;
        while ((idx < 4 || exp_q.size() != 0) && budget < 100) begin
            @(negedge clk);
            budget++;
            if (bus.out_valid && !seen) begin seen = 1'b1; hold = 5; end
            bus.out_ready = (hold == 0);
            if (hold > 0) hold--;
            if (idx < 4) set_in(1'b1, 8'(idx + 1), 3'd1, 2'b00, 1'b0);
            else bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
                n_cmp++; if (bus.data_out !== 8'h02) begin n_bad++; $display("FAIL stall_hold got=%h exp=02", bus.data_out); end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL stall_unexpected got=%h exp=none", bus.data_out);
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    if (bus.data_out !== e.data) begin n_bad++; $display("FAIL stall_data got=%h exp=%h", bus.data_out, e.data); end
                    n_cmp++; if (bus.out_lost !== e.lost) begin n_bad++; $display("FAIL stall_lost got=%b exp=%b", bus.out_lost, e.lost); end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back('{8'((idx + 1) * 2), 1'b0, cyc});
                idx++;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        n_cmp++; if (got != 4) begin n_bad++; $display("FAIL stall_count got=%0d exp=4", got); end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [W:0]  r;
        int unsigned idx;
        int unsigned got;
        int unsigned budget;
        idx = 0;
        got = 0;
        budget = 0;
        while ((idx < 40 || exp_q.size() != 0) && budget < 2000) begin
            @(negedge clk);
            budget++;
            bus.out_ready = ($urandom_range(0, 4) > 1);
            if (idx < 40 && $urandom_range(0, 3) != 0)
                set_in(1'b1, 8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            else
                bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL b2b_unexpected got=%h exp=none", bus.data_out);
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    if (bus.data_out !== e.data) begin n_bad++; $display("FAIL b2b_data got=%h exp=%h", bus.data_out, e.data); end
                    n_cmp++; if (bus.out_lost !== e.lost) begin n_bad++; $display("FAIL b2b_lost got=%b exp=%b", bus.out_lost, e.lost); end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                r = model(bus.data_in, bus.select, bus.mode, bus.dir);
                exp_q.push_back('{r[7:0], r[8], cyc});
                idx++;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        n_cmp++; if (got != 40) begin n_bad++; $display("FAIL b2b_count got=%0d exp=40", got); end
    endtask

    task automatic test_reset_flush();
        exp_t        e;
        int unsigned sent;
        int unsigned budget;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_in(1'b1, 8'(8'h11 * (i + 1)), 3'd2, 2'b00, 1'b0);
            #1;
            if (bus.in_ready) exp_q.push_back('{8'h00, 1'b0, cyc});
        end
        @(posedge clk);
        #2;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_full got=%b exp=1", bus.out_valid); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid); end
        exp_q.delete();
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sent = 0;
        budget = 0;
        while ((sent < 1 || exp_q.size() != 0) && budget < 30) begin
            @(negedge clk);
            budget++;
            if (sent < 1) set_in(1'b1, 8'h3C, 3'd2, 2'b10, 1'b1);
            else bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL flush_stale got=%h exp=none", bus.data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.data_out !== e.data) begin n_bad++; $display("FAIL flush_data got=%h exp=%h", bus.data_out, e.data); end
                    n_cmp++; if (bus.out_lost !== e.lost) begin n_bad++; $display("FAIL flush_lost got=%b exp=%b", bus.out_lost, e.lost); end
                    n_cmp++; if (cyc - e.t !== 3) begin n_bad++; $display("FAIL flush_latency got=%0d exp=3", cyc - e.t); end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back('{8'h0F, 1'b0, cyc});
                sent++;
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (sent != 1 || exp_q.size() != 0) begin n_bad++; $display("FAIL flush_timeout got=%0d/%0d exp=1/0", sent, exp_q.size()); end
    endtask

    initial begin
        set_in(1'b0, 8'h00, 3'd0, 2'b00, 1'b0);
        bus.out_ready = 1'b1;
        rst = 1'b1;
        test_reset();
        test_vectors();
        test_stall();
        test_back_to_back();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
